// File: rtl/press_cond_pkg.sv
// Shared types and 50 MHz defaults for the pushbutton conditioning path.
package press_cond_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    DOWN,
    RELEASE_WAIT
  } state_e;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1_000_000;  // 20 ms at 50 MHz
  localparam int unsigned DEFAULT_HOLD_CYCLES     = 50_000_000; // 1 s at 50 MHz

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level inputs; the reset value is chosen
// per instance so the downstream logic sees a benign level out of reset.
module sync2 #(
  parameter int unsigned           WIDTH   = 1,
  parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // NOTE: non-blocking assignments so both stages sample on the same edge;
  // blocking here would collapse the chain into a single flop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/press_conditioner.sv
// Debounces the pushbutton, hands one sampled switch bit per clean press to the
// consumer over valid/ready, and flags long presses and dropped presses.
module press_conditioner
  import press_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES, // must be >= 2
  parameter int unsigned HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
  parameter int unsigned CNT_W           = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  input  logic sw_bit,
  input  logic bit_ready,
  output logic bit_valid,
  output logic bit_value,
  output logic pressed,
  output logic long_press,
  output logic overrun
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(HOLD_CYCLES);

  logic       w_key_n_s;
  logic       w_sw_s;
  state_e     r_state;
  state_e     w_next_state;
  logic       w_accept;
  logic       w_xfer;
  logic       w_held;
  logic [CNT_W-1:0] r_deb_cnt;
  logic [CNT_W-1:0] r_hold_cnt;
  logic       r_bit_valid;
  logic       r_bit_value;
  logic       r_pressed;
  logic       r_long_press;
  logic       r_overrun;

  sync2 #(.WIDTH(1), .RST_VAL(1'b1)) u_sync_key (
    .clk (clk),
    .rst (rst),
    .i_d (key_n),
    .o_q (w_key_n_s)
  );

  sync2 #(.WIDTH(1), .RST_VAL(1'b0)) u_sync_sw (
    .clk (clk),
    .rst (rst),
    .i_d (sw_bit),
    .o_q (w_sw_s)
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  // NOTE: defaults first so every path assigns every output; no latches.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      IDLE:         if (!w_key_n_s) w_next_state = PRESS_WAIT;
      PRESS_WAIT: begin
        if (w_key_n_s) begin
          w_next_state = IDLE;
        end else if (r_deb_cnt == DEB_LAST) begin
          w_next_state = DOWN;
          w_accept     = 1'b1;
        end
      end
      DOWN:         if (w_key_n_s) w_next_state = RELEASE_WAIT;
      RELEASE_WAIT: begin
        if (!w_key_n_s)                   w_next_state = DOWN;
        else if (r_deb_cnt == DEB_LAST)   w_next_state = IDLE;
      end
      default:      w_next_state = IDLE;
    endcase
  end

  // The sample that triggers entry to a wait state is the first stable one,
  // so the count starts at 1 and DEBOUNCE_CYCLES samples in total commit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_deb_cnt <= '0;
    end else if (w_next_state == PRESS_WAIT || w_next_state == RELEASE_WAIT) begin
      r_deb_cnt <= (w_next_state == r_state) ? r_deb_cnt + CNT_W'(1) : CNT_W'(1);
    end else begin
      r_deb_cnt <= '0;
    end
  end

  assign w_held = (r_state == DOWN) || (r_state == RELEASE_WAIT);

  // Saturating at HOLD_CYCLES keeps the pulse single; bounces back to DOWN keep the count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hold_cnt   <= '0;
      r_long_press <= 1'b0;
    end else begin
      r_long_press <= 1'b0;
      if (w_accept) begin
        r_hold_cnt <= '0;
      end else if (w_held && r_hold_cnt != HOLD_SAT) begin
        r_hold_cnt   <= r_hold_cnt + CNT_W'(1);
        r_long_press <= (r_hold_cnt == HOLD_LAST);
      end
    end
  end

  assign w_xfer = r_bit_valid && bit_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_bit_valid <= 1'b0;
      r_bit_value <= 1'b0;
      r_overrun   <= 1'b0;
      r_pressed   <= 1'b0;
    end else begin
      r_pressed <= (w_next_state == DOWN) || (w_next_state == RELEASE_WAIT);
      if (w_accept) begin
        if (!r_bit_valid || w_xfer) begin
          r_bit_valid <= 1'b1;
          r_bit_value <= w_sw_s;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_xfer) begin
        r_bit_valid <= 1'b0;
      end
    end
  end

  assign bit_valid  = r_bit_valid;
  assign bit_value  = r_bit_value;
  assign pressed    = r_pressed;
  assign long_press = r_long_press;
  assign overrun    = r_overrun;

endmodule
